// File: rtl/dino_score_keeper_pkg.sv
// rtl/dino_score_keeper_pkg.sv - shared types and constants for the dino score keeper
package dino_score_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

endpackage

// File: rtl/dino_score_keeper_if.sv
// rtl/dino_score_keeper_if.sv - game strobes in, score/display/sound signals out
interface dino_score_keeper_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    game_start;
  logic                    game_over;
  logic                    game_tick;
  logic [4*NUM_DIGITS-1:0] score;
  logic [4*NUM_DIGITS-1:0] hi_score;
  logic                    running;
  logic                    new_hi;
  logic                    saturated;
  logic                    score_pulse;

  modport master (
    output game_start, game_over, game_tick,
    input  score, hi_score, running, new_hi, saturated, score_pulse
  );

  modport slave (
    input  game_start, game_over, game_tick,
    output score, hi_score, running, new_hi, saturated, score_pulse
  );

endinterface

// File: rtl/dino_score_keeper_bcd_digit_counter.sv
// rtl/dino_score_keeper_bcd_digit_counter.sv - one BCD digit, wraps 9 -> 0 with carry out
module bcd_digit_counter
  import dino_score_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/dino_score_keeper.sv
// rtl/dino_score_keeper.sv - BCD score, tick prescaler, game FSM and session high score
module dino_score_keeper
  import dino_score_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_POINT = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  dino_score_keeper_if.slave  bus
);

  localparam int               SCORE_W  = BCD_W * NUM_DIGITS;
  localparam int               CNT_W    = $clog2(TICKS_PER_POINT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_POINT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SCORE_W-1:0] hi_score_q, hi_score_d;
  logic               new_hi_q, new_hi_d;
  logic               saturated_q, saturated_d;
  logic               score_pulse_q, score_pulse_d;
  logic               running_q, running_d;
  logic               start_prev_q, over_prev_q, tick_prev_q;

  logic               start_edge, over_edge, tick_edge;
  logic               score_clr, point_due, all_nines;
  logic [SCORE_W-1:0] score_w;
  logic [NUM_DIGITS-1:0] digit_inc, digit_carry, digit_is_max;
  logic               unused_top_carry;

  assign start_edge = bus.game_start & ~start_prev_q;
  assign over_edge  = bus.game_over  & ~over_prev_q;
  assign tick_edge  = bus.game_tick  & ~tick_prev_q;

  // Increment is gated before the chain so all-nines holds instead of wrapping.
  assign all_nines        = &digit_is_max;
  assign unused_top_carry = digit_carry[NUM_DIGITS-1];

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_lsd
        assign digit_inc[g] = point_due & ~all_nines;
      end else begin : g_upper
        assign digit_inc[g] = digit_carry[g-1];
      end
      assign digit_is_max[g] = (score_w[g*BCD_W +: BCD_W] == BCD_MAX);

      bcd_digit_counter u_digit (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (score_clr),
        .inc   (digit_inc[g]),
        .q     (score_w[g*BCD_W +: BCD_W]),
        .carry (digit_carry[g])
      );
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    hi_score_d    = hi_score_q;
    new_hi_d      = new_hi_q;
    saturated_d   = saturated_q;
    score_pulse_d = 1'b0;
    score_clr     = 1'b0;
    point_due     = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d     = RUN;
          score_clr   = 1'b1;
          tick_cnt_d  = '0;
          saturated_d = 1'b0;
          new_hi_d    = 1'b0;
        end
      end
      RUN: begin
        // Over takes priority: a coincident tick or start is dropped.
        if (over_edge) begin
          state_d = OVER;
          if (score_w > hi_score_q) begin
            hi_score_d = score_w;
            new_hi_d   = 1'b1;
          end else begin
            new_hi_d   = 1'b0;
          end
        end else if (tick_edge) begin
          if (tick_cnt_q == CNT_LAST) begin
            tick_cnt_d = '0;
            point_due  = 1'b1;
            if (all_nines) begin
              saturated_d = 1'b1;
            end else begin
              score_pulse_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      hi_score_q    <= '0;
      new_hi_q      <= 1'b0;
      saturated_q   <= 1'b0;
      score_pulse_q <= 1'b0;
      running_q     <= 1'b0;
      start_prev_q  <= 1'b0;
      over_prev_q   <= 1'b0;
      tick_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      hi_score_q    <= hi_score_d;
      new_hi_q      <= new_hi_d;
      saturated_q   <= saturated_d;
      score_pulse_q <= score_pulse_d;
      running_q     <= running_d;
      start_prev_q  <= bus.game_start;
      over_prev_q   <= bus.game_over;
      tick_prev_q   <= bus.game_tick;
    end
  end

  assign bus.score       = score_w;
  assign bus.hi_score    = hi_score_q;
  assign bus.running     = running_q;
  assign bus.new_hi      = new_hi_q;
  assign bus.saturated   = saturated_q;
  assign bus.score_pulse = score_pulse_q;

endmodule

// File: tb/tb_dino_score_keeper.sv
// tb/tb_dino_score_keeper.sv - directed bench: default 4-digit/6-tick keeper and a 2-digit/1-tick keeper
module tb_dino_score_keeper;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   pc1;
  int   pc2;
  int   base;

  dino_score_keeper_if #(.NUM_DIGITS(4)) if1 ();
  dino_score_keeper_if #(.NUM_DIGITS(2)) if2 ();

  dino_score_keeper #(.NUM_DIGITS(4), .TICKS_PER_POINT(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  dino_score_keeper #(.NUM_DIGITS(2), .TICKS_PER_POINT(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pc1 = 0;
    pc2 = 0;
  end

  always @(negedge clk) begin
    if (if1.score_pulse) pc1 = pc1 + 1;
    if (if2.score_pulse) pc2 = pc2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start1();
    if1.game_start = 1'b1; cyc();
    if1.game_start = 1'b0; cyc();
  endtask

  task automatic over1();
    if1.game_over = 1'b1; cyc();
    if1.game_over = 1'b0; cyc();
  endtask

  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      if1.game_tick = 1'b1; cyc();
      if1.game_tick = 1'b0; cyc();
    end
  endtask

  task automatic tick2(input int n);
    for (int i = 0; i < n; i++) begin
      if2.game_tick = 1'b1; cyc();
      if2.game_tick = 1'b0; cyc();
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    if1.game_start = 1'b0;
    if1.game_over  = 1'b0;
    if1.game_tick  = 1'b0;
    if2.game_start = 1'b0;
    if2.game_over  = 1'b0;
    if2.game_tick  = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc();

    check("rst_score",     32'(if1.score), 32'h0);
    check("rst_hi",        32'(if1.hi_score), 32'h0);
    check("rst_running",   32'(if1.running), 32'h0);
    check("rst_new_hi",    32'(if1.new_hi), 32'h0);
    check("rst_saturated", 32'(if1.saturated), 32'h0);

    tick1(6);
    check("idle_tick_ignored", 32'(if1.score), 32'h0);

    start1();
    check("run_after_start", 32'(if1.running), 32'h1);
    base = pc1;
    tick1(60);
    check("score_60_ticks", 32'(if1.score), 32'h0010);
    check("pulses_60_ticks", 32'(pc1 - base), 32'd10);
    check("running_60", 32'(if1.running), 32'h1);

    over1();
    check("over1_running", 32'(if1.running), 32'h0);
    check("over1_new_hi",  32'(if1.new_hi), 32'h1);
    check("over1_hi",      32'(if1.hi_score), 32'h0010);
    tick1(6);
    check("over_tick_ignored", 32'(if1.score), 32'h0010);

    start1();
    check("restart_clear", 32'(if1.score), 32'h0);
    check("restart_new_hi_clr", 32'(if1.new_hi), 32'h0);
    tick1(30);
    over1();
    check("g2_score",  32'(if1.score), 32'h0005);
    check("g2_hi",     32'(if1.hi_score), 32'h0010);
    check("g2_new_hi", 32'(if1.new_hi), 32'h0);

    // tick_cnt ends at 5 with score 3, then over and tick coincide
    start1();
    tick1(23);
    check("pre_sim_score", 32'(if1.score), 32'h0003);
    base = pc1;
    if1.game_over = 1'b1;
    if1.game_tick = 1'b1;
    cyc();
    if1.game_over = 1'b0;
    if1.game_tick = 1'b0;
    cyc(3);
    check("sim_running", 32'(if1.running), 32'h0);
    check("sim_score",   32'(if1.score), 32'h0003);
    check("sim_no_pulse", 32'(pc1 - base), 32'd0);
    check("sim_hi_kept", 32'(if1.hi_score), 32'h0010);

    // start held high: must restart exactly once
    if1.game_start = 1'b1;
    cyc(2);
    check("held_start_run", 32'(if1.running), 32'h1);
    tick1(6);
    cyc(2);
    if1.game_start = 1'b0;
    cyc();
    check("held_start_once", 32'(if1.score), 32'h0001);
    tick1(12);
    check("score_3", 32'(if1.score), 32'h0003);
    start1();
    check("start_in_run_score", 32'(if1.score), 32'h0003);
    check("start_in_run_running", 32'(if1.running), 32'h1);
    tick1(6);
    check("start_in_run_counts", 32'(if1.score), 32'h0004);

    // two-digit, every tick scores
    if2.game_start = 1'b1; cyc();
    if2.game_start = 1'b0; cyc();
    base = pc2;
    tick2(9);
    check("d2_score_9", 32'(if2.score), 32'h09);
    tick2(1);
    check("d2_carry_10", 32'(if2.score), 32'h10);
    tick2(89);
    check("d2_score_99", 32'(if2.score), 32'h99);
    check("d2_pulses_99", 32'(pc2 - base), 32'd99);
    check("d2_not_sat", 32'(if2.saturated), 32'h0);
    tick2(1);
    check("d2_sat_hold", 32'(if2.score), 32'h99);
    check("d2_sat_flag", 32'(if2.saturated), 32'h1);
    check("d2_sat_no_pulse", 32'(pc2 - base), 32'd99);

    // asynchronous reset mid-game
    rst_n = 1'b0;
    #2;
    check("midrst_score",   32'(if1.score), 32'h0);
    check("midrst_hi",      32'(if1.hi_score), 32'h0);
    check("midrst_running", 32'(if1.running), 32'h0);
    check("midrst_sat2",    32'(if2.saturated), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    tick1(6);
    check("midrst_idle", 32'(if1.score), 32'h0);
    check("midrst_idle_run", 32'(if1.running), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
